// File: rtl/pc_pkg.sv
// Shared defaults and next-PC source encoding for the program-counter unit.
package pc_pkg;

    localparam int unsigned XLEN_DEF       = 32;
    localparam int unsigned RAS_DEPTH_DEF  = 4;
    localparam int unsigned ILEN_BYTES_DEF = 4;
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BRANCH,
        NPC_JUMP,
        NPC_TRAP
    } npc_sel_t;

    // Fixed priority: trap > jump > branch > sequential.
    function automatic npc_sel_t npc_select(input logic trap,
                                            input logic jump_valid,
                                            input logic branch_taken);
        npc_sel_t sel;
        sel = NPC_SEQ;
        if (trap)
            sel = NPC_TRAP;
        else if (jump_valid)
            sel = NPC_JUMP;
        else if (branch_taken)
            sel = NPC_BRANCH;
        return sel;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop and in-place replace of the top entry.
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              push_data,
    output logic [XLEN-1:0]              top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         underflow_c
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic             empty;
    logic             full;

    // ptr addresses the next free slot; the top sits one below it.
    assign top_idx     = ptr - PTR_W'(1);
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(RAS_DEPTH));
    assign top         = empty ? '0 : entries[top_idx];
    assign underflow_c = pop && empty;

    // A push when full wraps ptr and overwrites the oldest entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++)
                entries[i] <= '0;
        end else if (push && (!pop || empty)) begin
            entries[ptr] <= push_data;
            ptr          <= ptr + PTR_W'(1);
            if (!full)
                count <= count + CNT_W'(1);
        end else if (push && pop) begin
            entries[top_idx] <= push_data;
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register with prioritised next-PC mux and return-address stack.
// Optional target alignment check: define PC_UNIT_MISALIGN_CHECK_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
    parameter int unsigned      RAS_DEPTH    = RAS_DEPTH_DEF,
    parameter int unsigned      ILEN_BYTES   = ILEN_BYTES_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pc_write_en,
    input  logic                        branch_taken,
    input  logic [XLEN-1:0]             branch_target,
    input  logic                        jump_valid,
    input  logic [XLEN-1:0]             jump_target,
    input  logic                        is_call,
    input  logic                        is_ret,
    input  logic                        trap,
    output logic [XLEN-1:0]             pc,
    output logic [XLEN-1:0]             pc_plus4,
    output logic [XLEN-1:0]             ras_top,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_mispredict,
    output logic                        ras_underflow,
    output logic                        misaligned
);

    npc_sel_t        npc_sel;
    logic [XLEN-1:0] npc_target;
    logic [XLEN-1:0] npc;
    logic            misalign_hit;
    logic            pc_update;
    logic            ras_en;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_underflow_c;

    assign pc_plus4 = pc + XLEN'(ILEN_BYTES);

    // Next-PC selection, with optional redirect of misaligned targets to the trap vector.
    always_comb begin
        npc_target   = pc_plus4;
        misalign_hit = 1'b0;
        npc_sel      = npc_select(trap, jump_valid, branch_taken);
        case (npc_sel)
            NPC_TRAP:   npc_target = TRAP_VECTOR;
            NPC_JUMP:   npc_target = jump_target;
            NPC_BRANCH: npc_target = branch_target;
            default:    npc_target = pc_plus4;
        endcase
`ifdef PC_UNIT_MISALIGN_CHECK_EN
        misalign_hit = (npc_sel != NPC_TRAP) && (npc_target[1:0] != 2'b00);
`endif
        npc = misalign_hit ? TRAP_VECTOR : npc_target;
    end

    // Trap bypasses the stall; RAS only moves on an accepted, non-faulting jump.
    assign pc_update = pc_write_en || trap;
    assign ras_en    = jump_valid && !trap && pc_write_en && !misalign_hit;
    assign ras_push  = ras_en && is_call;
    assign ras_pop   = ras_en && is_ret;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push        (ras_push),
        .pop         (ras_pop),
        .push_data   (pc_plus4),
        .top         (ras_top),
        .count       (ras_count),
        .underflow_c (ras_underflow_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_VECTOR;
            ras_mispredict <= 1'b0;
            ras_underflow  <= 1'b0;
            misaligned     <= 1'b0;
        end else begin
            if (pc_update)
                pc <= npc;
            ras_mispredict <= ras_pop && (ras_count != '0) && (ras_top != jump_target);
            ras_underflow  <= ras_underflow_c;
            misaligned     <= pc_update && misalign_hit;
        end
    end

endmodule
